// File: rtl/start_ack_ctrl.sv
// start_ack_ctrl: Start/Ack launch responder with optional data-memory clear sweep, run-cycle counter and watchdog
module start_ack_ctrl #(
  parameter int AW       = 8,
  parameter bit CLR_EN   = 1'b0,
  parameter int CLR_BASE = 0,
  parameter int CLR_LEN  = 256,
  parameter int CW       = 16,
  parameter int WDOG     = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  output logic          Ack,
  output logic          CoreRst,
  output logic          PcEn,
  output logic          DmWe,
  output logic [AW-1:0] DmAddr,
  output logic [7:0]    DmDin,
  output logic [CW-1:0] Cycles,
  output logic          Timeout
);
  typedef enum logic [2:0] {IDLE, HOLD, CLEAR, RUN, DONE} state_t;
  localparam logic [AW:0]   CLR_LAST = (AW+1)'(CLR_LEN - 1);
  localparam logic [AW-1:0] BASE     = AW'(CLR_BASE);
  state_t        state, state_nx;
  logic          start_q;
  logic [AW:0]   clr_left;
  logic [CW-1:0] cycles_nx;
  logic          fall, wd_hit;
  assign fall      = start_q & ~Start;
  assign cycles_nx = &Cycles ? Cycles : Cycles + 1'b1;
  assign wd_hit    = (WDOG != 0) && (64'(cycles_nx) >= 64'(WDOG));
  // Outputs decode only the state register, so no input reaches an output combinationally
  assign Ack     = state == DONE;
  assign CoreRst = state == IDLE || state == HOLD || state == CLEAR;
  assign PcEn    = state == RUN;
  assign DmWe    = state == CLEAR;
  assign DmDin   = '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Start ? HOLD : IDLE;
      HOLD:    state_nx = fall ? (CLR_EN ? CLEAR : RUN) : HOLD;
      CLEAR:   state_nx = Start ? HOLD : ((clr_left == '0) ? RUN : CLEAR);
      RUN:     state_nx = Start ? HOLD : ((Halt || wd_hit) ? DONE : RUN);
      DONE:    state_nx = Start ? HOLD : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      clr_left <= '0;
      DmAddr   <= '0;
      Cycles   <= '0;
      Timeout  <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= Start;
      if (state_nx == HOLD) begin
        Cycles  <= '0;
        Timeout <= 1'b0;
      end else if (state == RUN) begin
        Cycles  <= cycles_nx;
        Timeout <= ~Halt & wd_hit;
      end
      if (state == HOLD) begin
        DmAddr   <= BASE;
        clr_left <= CLR_LAST;
      end else if (state == CLEAR) begin
        DmAddr   <= DmAddr + 1'b1;
        clr_left <= clr_left - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_start_ack_ctrl.sv
// tb_start_ack_ctrl: two configurations driven by shared Start/Reset; per-launch results scoreboarded against a run-level model
module tb_start_ack_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b1, halt_a = 1'b0, halt_b = 1'b0;
  logic ack_a, corerst_a, pcen_a, dmwe_a, timeout_a;
  logic ack_b, corerst_b, pcen_b, dmwe_b, timeout_b;
  logic [7:0] dmaddr_a, dmdin_a, dmaddr_b, dmdin_b;
  logic [3:0] cycles_a;
  logic [15:0] cycles_b;
  typedef struct {int cyc; int run; bit to;} exp_t;
  exp_t qa[$], qb[$];
  int checks = 0, failures = 0;
  int run_a = 0, run_b = 0, we_n = 0;
  logic ack_pa = 1'b0, ack_pb = 1'b0, we_pb = 1'b0, start_p = 1'b0;

  start_ack_ctrl #(.AW(8), .CLR_EN(1'b0), .CW(4), .WDOG(0)) dut_a (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt_a), .Ack(ack_a), .CoreRst(corerst_a),
    .PcEn(pcen_a), .DmWe(dmwe_a), .DmAddr(dmaddr_a), .DmDin(dmdin_a), .Cycles(cycles_a), .Timeout(timeout_a));
  start_ack_ctrl #(.AW(8), .CLR_EN(1'b1), .CLR_BASE(250), .CLR_LEN(8), .CW(16), .WDOG(16)) dut_b (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt_b), .Ack(ack_b), .CoreRst(corerst_b),
    .PcEn(pcen_b), .DmWe(dmwe_b), .DmAddr(dmaddr_b), .DmDin(dmdin_b), .Cycles(cycles_b), .Timeout(timeout_b));

  always #5 clk = ~clk;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic ack_seen(input bit b, input longint cyc, input bit to, input int run);
    exp_t e;
    string p = b ? "B" : "A";
    if ((b ? qb.size() : qa.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s ack: got unexpected Ack expected no Ack", p);
    end else begin
      e = b ? qb.pop_front() : qa.pop_front();
      chk({p, " cycles"}, cyc, e.cyc);
      chk({p, " timeout"}, to, e.to);
      chk({p, " run length"}, run, e.run);
    end
  endtask

  task automatic rst_chk();
    chk("A reset flags", {ack_a, corerst_a, pcen_a, dmwe_a, timeout_a}, 5'b01000);
    chk("A reset addr/cycles", {dmaddr_a, cycles_a}, 0);
    chk("B reset flags", {ack_b, corerst_b, pcen_b, dmwe_b, timeout_b}, 5'b01000);
    chk("B reset addr/cycles", {dmaddr_b, cycles_b}, 0);
  endtask

  // run cycle at which a config stops by itself (halt or watchdog); 0 = never
  function automatic int fin(input int h, input int w);
    return (h != 0 && (w == 0 || h <= w)) ? h : w;
  endfunction

  task automatic launch(input int ha, input int hb, input int a);
    int fa = fin(ha, 0), fb = fin(hb, 16);
    bit ab_a = a != 0 && (fa == 0 || a <= fa);
    bit ab_b = a != 0 && (a <= 8 || a - 8 <= fb);
    int end_a = ab_a ? a : fa, end_b = ab_b ? a : 8 + fb;
    int tt = (end_a > end_b ? end_a : end_b) + 2;
    if (!ab_a) qa.push_back('{fa > 15 ? 15 : fa, fa, 1'b0});
    if (!ab_b) qb.push_back('{fb, fb, !(hb != 0 && hb <= 16)});
    @(posedge clk); #1;
    start = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      halt_a = 1'($urandom);
      halt_b = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int t = 0; t < tt; t++) begin
      @(posedge clk); #1;
      halt_a = (t + 1 <= end_a) ? (t + 1 == ha) : 1'($urandom);
      halt_b = (t + 1 > 8 && t + 1 <= end_b) ? (t + 1 - 8 == hb) : 1'($urandom);
      start  = a != 0 && t + 1 >= a;
    end
  endtask

  always @(negedge clk) start_p <= start;

  always @(negedge clk) begin
    if (!rst) begin
      if (corerst_a) chk("A quiescent", {ack_a, pcen_a, timeout_a, dmwe_a, cycles_a}, 0);
      if (pcen_a) chk("A run outputs", {corerst_a, ack_a, dmwe_a}, 0);
      if (ack_a) chk("A done outputs", {pcen_a, corerst_a, dmwe_a}, 0);
      if (ack_a && !ack_pa) ack_seen(1'b0, cycles_a, timeout_a, run_a);
      if (ack_pa && !ack_a) chk("A ack held until Start", start_p, 1);
    end
    run_a  <= corerst_a ? 0 : run_a + int'(pcen_a);
    ack_pa <= ack_a;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (corerst_b) chk("B quiescent", {ack_b, pcen_b, timeout_b, cycles_b}, 0);
      if (pcen_b) chk("B run outputs", {corerst_b, ack_b, dmwe_b}, 0);
      if (ack_b) chk("B done outputs", {pcen_b, corerst_b, dmwe_b}, 0);
      if (dmwe_b) begin
        chk("B clear addr", dmaddr_b, (250 + we_n) % 256);
        chk("B clear data/corerst", {dmdin_b, corerst_b}, 1);
      end
      if (we_pb && !dmwe_b && pcen_b) chk("B clear length", we_n, 8);
      if (ack_b && !ack_pb) ack_seen(1'b1, cycles_b, timeout_b, run_b);
      if (ack_pb && !ack_b) chk("B ack held until Start", start_p, 1);
    end
    run_b  <= corerst_b ? 0 : run_b + int'(pcen_b);
    we_n   <= dmwe_b ? we_n + 1 : 0;
    we_pb  <= dmwe_b;
    ack_pb <= ack_b;
  end

  initial begin
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      rst_chk();
    end
    rst = 1'b0;
    launch(10, 10, 0);
    launch(20, 0, 0);
    launch(16, 16, 0);
    launch(0, 0, 13);
    launch(0, 3, 5);
    launch(12, 12, 0);
    for (int i = 0; i < 20; i++) begin
      int ha = $urandom_range(0, 22), hb = $urandom_range(0, 22);
      int a = $urandom_range(0, 1) != 0 ? $urandom_range(1, 30) : 0;
      if (ha == 0 && a == 0) a = $urandom_range(1, 30);
      launch(ha, hb, a);
    end
    // reset in the middle of a sweep, just after the address wraps
    @(posedge clk); #1;
    start = 1'b1;
    halt_a = 1'b0;
    halt_b = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !(dmwe_b && dmaddr_b == 8'd0); i++) @(negedge clk);
    chk("B sweep reaches addr 0", {dmwe_b, dmaddr_b}, 9'h100);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_chk();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("A pending results", qa.size(), 0);
    chk("B pending results", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
